// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner: time-multiplexed BCD seven-segment display controller.
// Holds an active frame of BCD digits plus one pending frame from the
// calculator core. It scans digit 0 up to NUM_DIGITS-1 with an optional
// all-off gap between digits. Pending values take effect only at frame wraps.
// Optional feature macro: SEVEN_SEG_DIM_EN adds a 2-bit brightness input
// that shortens the lit part of each digit dwell.
module seven_seg_scanner #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 1000,
    parameter int GAP_CYCLES  = 2
) (
    input  logic                    clk,
    input  logic                    nrst,
    input  logic                    load_valid,
    output logic                    load_ready,
    input  logic [4*NUM_DIGITS-1:0] load_value,
    input  logic                    blank_lz,
`ifdef SEVEN_SEG_DIM_EN
    input  logic [1:0]              brightness,
`endif
    output logic [3:0]              digit_code,
    output logic [NUM_DIGITS-1:0]   digit_sel,
    output logic                    frame_done
);

    localparam int IDX_W = (NUM_DIGITS  > 1) ? $clog2(NUM_DIGITS)  : 1;
    localparam int DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int GAP_W = (GAP_CYCLES  > 1) ? $clog2(GAP_CYCLES)  : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    // Control state
    state_t                  r_state;
    logic [IDX_W-1:0]        r_idx;
    logic [DIV_W-1:0]        r_div_cnt;
    logic [GAP_W-1:0]        r_gap_cnt;
    logic [4*NUM_DIGITS-1:0] r_active;
    logic [4*NUM_DIGITS-1:0] r_pending;
    logic                    r_pending_full;

    // Registered outputs
    logic [NUM_DIGITS-1:0]   r_digit_sel;
    logic [3:0]              r_digit_code;
    logic                    r_load_ready;
    logic                    r_frame_done;

    // Next-state values
    state_t                  w_state_nxt;
    logic [IDX_W-1:0]        w_idx_nxt;
    logic [DIV_W-1:0]        w_div_nxt;
    logic [GAP_W-1:0]        w_gap_nxt;
    logic [4*NUM_DIGITS-1:0] w_active_nxt;
    logic [4*NUM_DIGITS-1:0] w_pending_nxt;
    logic                    w_pfull_nxt;
    logic                    w_step;
    logic                    w_wrap;

    // Display decode values
    logic [NUM_DIGITS-1:0]   w_upper_zero;
    logic [3:0]              w_digit;
    logic [3:0]              w_resolved;
    logic                    w_lit;
    logic [NUM_DIGITS-1:0]   w_sel_nxt;
    logic [3:0]              w_code_nxt;

    logic w_transfer;
    logic w_div_last;
    logic w_gap_last;

    assign w_transfer = load_valid && r_load_ready;
    assign w_div_last = (r_div_cnt == DIV_W'(REFRESH_DIV - 1));
    assign w_gap_last = (r_gap_cnt == GAP_W'(GAP_CYCLES - 1));

    // Next-state logic: dwell/gap counting, digit stepping and the frame-buffer handoff
    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        w_state_nxt   = r_state;
        w_idx_nxt     = r_idx;
        w_div_nxt     = r_div_cnt;
        w_gap_nxt     = r_gap_cnt;
        w_active_nxt  = r_active;
        w_pending_nxt = r_pending;
        w_pfull_nxt   = r_pending_full;
        w_step        = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_transfer) begin
                    w_state_nxt  = ST_SCAN;
                    w_idx_nxt    = '0;
                    w_div_nxt    = '0;
                    w_active_nxt = load_value;
                end
            end
            ST_SCAN: begin
                if (w_div_last) begin
                    w_div_nxt = '0;
                    if (GAP_CYCLES == 0) begin
                        w_step = 1'b1;
                    end else begin
                        w_state_nxt = ST_GAP;
                        w_gap_nxt   = '0;
                    end
                end else begin
                    w_div_nxt = r_div_cnt + DIV_W'(1);
                end
            end
            ST_GAP: begin
                if (w_gap_last) begin
                    w_step = 1'b1;
                end else begin
                    w_gap_nxt = r_gap_cnt + GAP_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        w_wrap = w_step && (r_idx == IDX_W'(NUM_DIGITS - 1));

        if (w_step) begin
            w_state_nxt = ST_SCAN;
            w_div_nxt   = '0;
            w_idx_nxt   = w_wrap ? '0 : r_idx + IDX_W'(1);
        end

        // While scanning, a frame boundary promotes the pending frame; otherwise
        // a new load is parked until the boundary (or goes live if it lands on one).
        if (r_state != ST_IDLE) begin
            if (w_wrap && r_pending_full) begin
                w_active_nxt = r_pending;
                w_pfull_nxt  = 1'b0;
            end else if (w_transfer && w_wrap) begin
                w_active_nxt = load_value;
            end else if (w_transfer) begin
                w_pending_nxt = load_value;
                w_pfull_nxt   = 1'b1;
            end
        end
    end

    // Display decode: resolve the current digit and select from the present state and index
    always_comb begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
            w_upper_zero[i] = ((r_active >> (4 * i)) == '0);
        end

        w_digit = r_active[{r_idx, 2'b00} +: 4];

        if (w_digit > 4'd9) begin
            w_resolved = 4'hF;
        end else if (blank_lz && (r_idx != '0) && w_upper_zero[r_idx]) begin
            w_resolved = 4'hF;
        end else begin
            w_resolved = w_digit;
        end

`ifdef SEVEN_SEG_DIM_EN
        w_lit = (32'(r_div_cnt) < (((32'(brightness) + 32'd1) * 32'(REFRESH_DIV)) / 32'd4));
`else
        w_lit = 1'b1;
`endif

        if ((r_state == ST_SCAN) && w_lit) begin
            w_sel_nxt  = ~(NUM_DIGITS'(1) << r_idx);
            w_code_nxt = w_resolved;
        end else begin
            w_sel_nxt  = '1;
            w_code_nxt = 4'hF;
        end
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!nrst) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values of the others.
            r_state        <= ST_IDLE;
            r_idx          <= '0;
            r_div_cnt      <= '0;
            r_gap_cnt      <= '0;
            r_active       <= '0;
            r_pending      <= '0;
            r_pending_full <= 1'b0;
            r_digit_sel    <= '1;
            r_digit_code   <= 4'hF;
            r_load_ready   <= 1'b1;
            r_frame_done   <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_idx          <= w_idx_nxt;
            r_div_cnt      <= w_div_nxt;
            r_gap_cnt      <= w_gap_nxt;
            r_active       <= w_active_nxt;
            r_pending      <= w_pending_nxt;
            r_pending_full <= w_pfull_nxt;
            r_digit_sel    <= w_sel_nxt;
            r_digit_code   <= w_code_nxt;
            r_load_ready   <= (w_state_nxt == ST_IDLE) || !w_pfull_nxt;
            r_frame_done   <= w_wrap;
        end
    end

    assign digit_sel  = r_digit_sel;
    assign digit_code = r_digit_code;
    assign load_ready = r_load_ready;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Testbench for seven_seg_scanner (NUM_DIGITS=4, REFRESH_DIV=4, GAP_CYCLES=1).
// The reference model tracks edges since the first load and derives the
// expected display from frame arithmetic.
module tb_seven_seg_scanner;

    localparam int ND    = 4;
    localparam int RD    = 4;
    localparam int GC    = 1;
    localparam int DWELL = RD + GC;
    localparam int FRAME = ND * DWELL;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic        load_valid = 1'b0;
    logic [15:0] load_value = '0;
    logic        blank_lz = 1'b0;
`ifdef SEVEN_SEG_DIM_EN
    logic [1:0]  brightness = 2'd3;
`endif
    logic        load_ready;
    logic [3:0]  digit_code;
    logic [3:0]  digit_sel;
    logic        frame_done;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model state
    bit          m_run   = 1'b0;
    int          m_n     = 0;
    logic [15:0] m_active  = '0;
    logic [15:0] m_pending = '0;
    bit          m_pfull = 1'b0;

    seven_seg_scanner #(
        .NUM_DIGITS (ND),
        .REFRESH_DIV(RD),
        .GAP_CYCLES (GC)
    ) dut (
        .clk       (clk),
        .nrst      (nrst),
        .load_valid(load_valid),
        .load_ready(load_ready),
        .load_value(load_value),
        .blank_lz  (blank_lz),
`ifdef SEVEN_SEG_DIM_EN
        .brightness(brightness),
`endif
        .digit_code(digit_code),
        .digit_sel (digit_sel),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    // Expected code for digit i of value v.
    function automatic logic [3:0] ref_code(input logic [15:0] v, input int i, input bit blz);
        int d;
        d = int'((v >> (4 * i)) & 16'hF);
        if (d > 9) return 4'hF;
        if (blz && (i > 0) && ((v >> (4 * i)) == 16'h0)) return 4'hF;
        return 4'(d);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    endtask

    // Advance one clock edge, update the model, check all outputs.
    task automatic step();
        logic [15:0] old_active;
        logic [15:0] v;
        logic [3:0]  e_sel;
        logic [3:0]  e_code;
        bit          e_done;
        bit          xfer;
        bit          rst;
        bit          blz;
        bit          wrap;
        int          p;
        int          slot;
        int          d;
        int          lit_len;

        old_active = m_active;
        v    = load_value;
        blz  = blank_lz;
        rst  = !nrst;
        xfer = load_valid && (!m_run || !m_pfull);
        lit_len = RD;
`ifdef SEVEN_SEG_DIM_EN
        lit_len = ((int'(brightness) + 1) * RD) / 4;
`endif
        e_sel  = 4'b1111;
        e_code = 4'hF;
        e_done = 1'b0;

        @(posedge clk);
        #1;

        if (rst) begin
            m_run = 1'b0; m_n = 0; m_active = '0; m_pending = '0; m_pfull = 1'b0;
        end else if (!m_run) begin
            if (xfer) begin
                m_run = 1'b1; m_n = 0; m_active = v;
            end
        end else begin
            m_n++;
            wrap = (m_n % FRAME) == 0;
            p    = (m_n - 1) % FRAME;
            slot = p / DWELL;
            d    = p % DWELL;
            if (d < lit_len && d < RD) begin
                e_sel  = ~(4'b0001 << slot);
                e_code = ref_code(old_active, slot, blz);
            end
            e_done = wrap;
            if (wrap && m_pfull) begin
                m_active = m_pending; m_pfull = 1'b0;
            end else if (xfer && wrap) begin
                m_active = v;
            end else if (xfer) begin
                m_pending = v; m_pfull = 1'b1;
            end
        end

        check("digit_sel",  32'(digit_sel),  32'(e_sel));
        check("digit_code", 32'(digit_code), 32'(e_code));
        check("frame_done", 32'(frame_done), 32'(e_done));
        check("load_ready", 32'(load_ready), 32'(!m_run || !m_pfull));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        nrst = 1'b0;
        step();
        nrst = 1'b1;
    endtask

    task automatic load(input logic [15:0] v);
        load_value = v;
        load_valid = 1'b1;
        step();
        load_valid = 1'b0;
    endtask

    function automatic logic [15:0] rand_value();
        logic [15:0] r;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            r = r | (16'(($urandom % 3 == 0) ? 0 : ($urandom % 16)) << (4 * i));
        end
        return r;
    endfunction

    initial begin
        // Reset and idle: dark display, ready, no frame_done
        nrst = 1'b0;
        step();
        step();
        nrst = 1'b1;
        run(10);

        // Basic scan of 1234 without blanking, two full frames
        blank_lz = 1'b0;
        load(16'h1234);
        run(41);

        // Leading-zero blanking: 0007, then 0000 loaded mid-frame
        do_reset();
        blank_lz = 1'b1;
        load(16'h0007);
        run(20);
        load(16'h0000);
        run(25);

        // Mid-frame load, then a refused second attempt held for several cycles
        do_reset();
        blank_lz = 1'b0;
        load(16'h1234);
        run(6);
        load(16'h5678);
        load_value = 16'h4321;
        load_valid = 1'b1;
        run(3);
        load_valid = 1'b0;
        run(40);

        // Codes above 9 blank; blanking stops at the first nonzero digit
        do_reset();
        blank_lz = 1'b1;
        load(16'h9AF0);
        run(21);

        // Load landing exactly on a frame wrap with nothing pending
        do_reset();
        blank_lz = 1'b0;
        load(16'h1111);
        run(19);
        load(16'h2222);
        run(21);

        // Randomized loads, values and live blank_lz changes
        do_reset();
        load(rand_value());
        for (int i = 0; i < 300; i++) begin
            load_valid = ($urandom % 4) == 0;
            load_value = rand_value();
            if (($urandom % 16) == 0) blank_lz = ~blank_lz;
            step();
        end
        load_valid = 1'b0;

        // Reset in the middle of digit 2's dwell aborts immediately
        do_reset();
        blank_lz = 1'b0;
        load(16'h1234);
        run(11);
        nrst = 1'b0;
        step();
        nrst = 1'b1;
        run(5);

`ifdef SEVEN_SEG_DIM_EN
        // Dimming: brightness 1 lights each digit for 2 of 4 dwell cycles
        brightness = 2'd1;
        do_reset();
        load(16'h1234);
        run(41);
        brightness = 2'd3;
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
